rr_mux4_arbiter: RTL

//  Round-robin arbiter/sequencer that shares one 4:1 datapath mux among four

---
 rtl/rr_mux4_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters, bounded bursts.
// Latency: req in cycle N gives gnt in N+1; out_data/out_valid combinational from registered selects.
// Backpressure: out_ready=0 holds the grant and freezes the beat count; one idle bubble between grants.
module rr_mux4_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic              out_ready,
  output logic [3:0]        gnt,
  output logic              sel1,
  output logic              sel2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] beat_cnt;
  logic [1:0] owner;
  logic [1:0] pick;
  logic       beat;
  logic       release_now;

  // The registered selects double as the owner index while granted.
  assign owner       = {sel2, sel1};
  assign busy        = (state == GRANT);
  assign out_valid   = busy & req[owner];
  assign beat        = out_valid & out_ready;
  // Release on the last allowed beat, or as soon as the owner withdraws its request.
  assign release_now = !out_valid || (beat && (beat_cnt == LAST_BEAT));

  // First set request searching from ptr upward, wrapping mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Datapath mux driven by the registered selects.
  always_comb begin
    out_data = in1;
    case (owner)
      2'd0:    out_data = in1;
      2'd1:    out_data = in2;
      2'd2:    out_data = in3;
      default: out_data = in4;
    endcase
  end

  // Grant sequencer: IDLE arbitrates, GRANT counts beats until release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel1     <= 1'b0;
      sel2     <= 1'b0;
      ptr      <= 2'd0;
      beat_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt         <= 4'b0001 << pick;
            {sel2, sel1} <= pick;
            beat_cnt    <= 4'd0;
            state       <= GRANT;
          end else begin
            gnt <= 4'b0000;
          end
        end
        default: begin
          if (release_now) begin
            gnt      <= 4'b0000;
            state    <= IDLE;
            ptr      <= owner + 2'd1;
            beat_cnt <= 4'd0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule
